cpu_clk_ctrl: RTL and testbench

Run/step sequencer for the tiny CPU. It produces a one-sysclk-wide clock-enable pulse, cpu_ce, for each CPU step. In autorun mode cpu_ce fires at a fixed divided rate. In step mode it fires once per short press of the debounced step button. A long press toggles between the two modes. The block sits between the board button/sysclk and the CPU core, and exports mode and clock-phase status bits to the debug LED frame.

---
 rtl/cpu_clk_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// Run/step sequencer: autorun divider or debounced step button driving a one-cycle cpu_ce.
// Optional step counter enabled by defining CPU_CLK_CTRL_STEP_COUNT_EN.
module cpu_clk_ctrl #(
  parameter int SYSCLK_FREQ     = 27000000,
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_TICKS  = SYSCLK_FREQ / TICK_DIV / 10,
  parameter int LONGPRESS_TICKS = SYSCLK_FREQ / TICK_DIV * 2,
  parameter int RUN_DIV_LOG2    = 21,
  parameter bit AUTORUN_INIT    = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        btn,
  input  logic        cpu_halt,
  output logic        cpu_ce,
  output logic        clk_view,
  output logic        autorun,
  output logic        btn_db,
  output logic [31:0] step_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]   DEB_LIM   = 16'(DEBOUNCE_TICKS);
  localparam logic [15:0]   LONG_LIM  = 16'(LONGPRESS_TICKS);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD_LONG, RELEASE_DEB} state_t;

  state_t                  state, state_nxt;
  logic                    btn_meta, btn_sync;
  logic [PW-1:0]           presc_cnt;
  logic                    tick;
  logic [15:0]             deb_cnt, deb_nxt;
  logic [15:0]             hold_cnt, hold_nxt;
  logic                    long_flag, long_nxt;
  logic                    btn_db_nxt;
  logic                    toggle;
  logic                    step_req;
  logic [RUN_DIV_LOG2-1:0] run_cnt;
  logic                    run_wrap;
  logic                    ce_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  assign tick = (presc_cnt == PRESC_MAX);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) presc_cnt <= '0;
    else       presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_flag <= 1'b0;
      btn_db    <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      hold_cnt  <= hold_nxt;
      long_flag <= long_nxt;
      btn_db    <= btn_db_nxt;
    end
  end

  // A bounce during release returns to the pressed state it came from, keeping hold_cnt.
  always_comb begin
    state_nxt  = state;
    deb_nxt    = deb_cnt;
    hold_nxt   = hold_cnt;
    long_nxt   = long_flag;
    btn_db_nxt = btn_db;
    toggle     = 1'b0;
    step_req   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (btn_sync) begin
            deb_nxt = sat_inc(deb_cnt);
            if (deb_nxt >= DEB_LIM) begin
              state_nxt  = PRESSED;
              btn_db_nxt = 1'b1;
              hold_nxt   = '0;
              long_nxt   = 1'b0;
              deb_nxt    = '0;
            end
          end else begin
            deb_nxt = '0;
          end
        end
        PRESSED: begin
          if (btn_sync) begin
            hold_nxt = sat_inc(hold_cnt);
            if (hold_nxt >= LONG_LIM) begin
              toggle    = 1'b1;
              long_nxt  = 1'b1;
              state_nxt = HELD_LONG;
            end
          end else begin
            state_nxt = RELEASE_DEB;
            deb_nxt   = 16'd1;
          end
        end
        HELD_LONG: begin
          if (!btn_sync) begin
            state_nxt = RELEASE_DEB;
            deb_nxt   = 16'd1;
          end
        end
        RELEASE_DEB: begin
          if (btn_sync) begin
            state_nxt = long_flag ? HELD_LONG : PRESSED;
            deb_nxt   = '0;
          end else begin
            deb_nxt = sat_inc(deb_cnt);
            if (deb_nxt >= DEB_LIM) begin
              state_nxt  = IDLE;
              btn_db_nxt = 1'b0;
              deb_nxt    = '0;
              step_req   = !long_flag && !autorun;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Halt wins over a long-press toggle and swallows a coinciding run pulse, not a manual step.
  assign run_wrap = autorun && (run_cnt == '1);
  assign ce_nxt   = step_req || (run_wrap && !cpu_halt);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cpu_ce   <= 1'b0;
      clk_view <= 1'b0;
      autorun  <= AUTORUN_INIT;
      run_cnt  <= '0;
    end else begin
      cpu_ce   <= ce_nxt;
      clk_view <= clk_view ^ cpu_ce;
      autorun  <= cpu_halt ? 1'b0 : (autorun ^ toggle);
      run_cnt  <= autorun ? run_cnt + 1'b1 : '0;
    end
  end

`ifdef CPU_CLK_CTRL_STEP_COUNT_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)       step_count <= '0;
    else if (ce_nxt) step_count <= step_count + 32'd1;
  end
`else
  assign step_count = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a 4-cycle tick, 2-tick debounce, 10-tick long press, 8-cycle run period.
module tb_cpu_clk_ctrl;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        btn;
  logic        cpu_halt;
  logic        cpu_ce;
  logic        clk_view;
  logic        autorun;
  logic        btn_db;
  logic [31:0] step_count;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int ce_count = 0;

`ifdef CPU_CLK_CTRL_STEP_COUNT_EN
  localparam bit SC_ON = 1'b1;
`else
  localparam bit SC_ON = 1'b0;
`endif

  cpu_clk_ctrl #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (2),
    .LONGPRESS_TICKS(10),
    .RUN_DIV_LOG2   (3),
    .AUTORUN_INIT   (1'b1)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .btn       (btn),
    .cpu_halt  (cpu_halt),
    .cpu_ce    (cpu_ce),
    .clk_view  (clk_view),
    .autorun   (autorun),
    .btn_db    (btn_db),
    .step_count(step_count)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) if (cpu_ce === 1'b1) ce_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge k after reset release; inputs driven and outputs sampled 1 time unit after it.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge sysclk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    btn      = 1'b0;
    cpu_halt = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_clk_view", {31'd0, clk_view}, 32'd0);
    chk("rst_autorun", {31'd0, autorun}, 32'd1);
    chk("rst_btn_db", {31'd0, btn_db}, 32'd0);
    chk("rst_step_count", step_count, 32'd0);
    reset = 1'b0;
    cyc   = 0;

    // autorun from reset: pulses at edges 8,16,24,32,40
    goto(7);   chk("run_ce_e7", {31'd0, cpu_ce}, 32'd0);
    goto(8);   chk("run_ce_e8", {31'd0, cpu_ce}, 32'd1);
               chk("run_view_e8", {31'd0, clk_view}, 32'd0);
    goto(9);   chk("run_ce_e9", {31'd0, cpu_ce}, 32'd0);
               chk("run_view_e9", {31'd0, clk_view}, 32'd1);
    goto(17);  chk("run_view_e17", {31'd0, clk_view}, 32'd0);
    goto(40);  chk("run_ce_e40", {31'd0, cpu_ce}, 32'd1);
               chk("run_autorun_e40", {31'd0, autorun}, 32'd1);

    // long press: debounce accepted at 48, toggle at 88 coincides with a run wrap
    btn = 1'b1;
    goto(45);  chk("run_count_5", ce_count, 32'd5);
    goto(47);  chk("lp_btn_db_e47", {31'd0, btn_db}, 32'd0);
    goto(48);  chk("lp_btn_db_e48", {31'd0, btn_db}, 32'd1);
    goto(87);  chk("lp_autorun_e87", {31'd0, autorun}, 32'd1);
    goto(88);  chk("lp_autorun_e88", {31'd0, autorun}, 32'd0);
               chk("lp_wrap_ce_e88", {31'd0, cpu_ce}, 32'd1);
    goto(100); btn = 1'b0;
    goto(107); chk("lp_btn_db_e107", {31'd0, btn_db}, 32'd1);
    goto(108); chk("lp_btn_db_e108", {31'd0, btn_db}, 32'd0);
    goto(120); chk("lp_count_11", ce_count, 32'd11);

    // short press in step mode: release confirmed at tick 148
    btn = 1'b1;
    goto(140); btn = 1'b0;
    goto(147); chk("sp_ce_e147", {31'd0, cpu_ce}, 32'd0);
    goto(148); chk("sp_ce_e148", {31'd0, cpu_ce}, 32'd1);
               chk("sp_view_e148", {31'd0, clk_view}, 32'd1);
    goto(149); chk("sp_ce_e149", {31'd0, cpu_ce}, 32'd0);
               chk("sp_view_e149", {31'd0, clk_view}, 32'd0);
    goto(160); chk("sp_count_12", ce_count, 32'd12);

    // bounce: six one-tick pulses never reach the debounce limit
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      goto(164 + 8 * i);
      btn = 1'b0;
      chk("bounce_btn_db", {31'd0, btn_db}, 32'd0);
      goto(168 + 8 * i);
    end
    goto(210); chk("bounce_btn_db_end", {31'd0, btn_db}, 32'd0);
               chk("bounce_count_12", ce_count, 32'd12);

    // long press back into autorun at 260; first run pulse a full period later
    btn = 1'b1;
    goto(259); chk("ar_autorun_e259", {31'd0, autorun}, 32'd0);
    goto(260); chk("ar_autorun_e260", {31'd0, autorun}, 32'd1);
    goto(267); chk("ar_ce_e267", {31'd0, cpu_ce}, 32'd0);
    goto(268); chk("ar_ce_e268", {31'd0, cpu_ce}, 32'd1);
    goto(270); btn = 1'b0;

    // halt on the cycle of a run wrap: pulse suppressed, autorun cleared
    goto(291); chk("halt_autorun_e291", {31'd0, autorun}, 32'd1);
    cpu_halt = 1'b1;
    goto(292); chk("halt_autorun_e292", {31'd0, autorun}, 32'd0);
               chk("halt_ce_e292", {31'd0, cpu_ce}, 32'd0);
    goto(300); chk("halt_count_15", ce_count, 32'd15);

    // single step while halted
    btn = 1'b1;
    goto(308); chk("hs_btn_db_e308", {31'd0, btn_db}, 32'd1);
    goto(316); btn = 1'b0;
    goto(323); chk("hs_ce_e323", {31'd0, cpu_ce}, 32'd0);
    goto(324); chk("hs_ce_e324", {31'd0, cpu_ce}, 32'd1);
               chk("hs_autorun_e324", {31'd0, autorun}, 32'd0);
    goto(330); chk("hs_count_16", ce_count, 32'd16);
               chk("sc_before_reset", step_count, SC_ON ? 32'd16 : 32'd0);
    cpu_halt = 1'b0;

    // reset clears the counter and restores autorun
    reset = 1'b1;
    #1;
    chk("sc_in_reset", step_count, 32'd0);
    chk("autorun_in_reset", {31'd0, autorun}, 32'd1);
    chk("view_in_reset", {31'd0, clk_view}, 32'd0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    goto(39);  chk("sc_e39", step_count, SC_ON ? 32'd4 : 32'd0);
    goto(40);  chk("sc_e40", step_count, SC_ON ? 32'd5 : 32'd0);
               chk("sc_ce_e40", {31'd0, cpu_ce}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
